// File: rtl/jedro_1_defines.sv
// Shared core definitions: bus width, boot address, canned instructions and
// the instruction-memory loader state encoding.
// Latency: n/a (package). Backpressure: n/a.
package jedro_1_defines;

  localparam int DATA_WIDTH = 32;

  // Reset vector; the instruction memory maps its word 0 here by default.
  localparam logic [DATA_WIDTH-1:0] BOOT_ADDR = 32'h0000_0000;

  // addi x0, x0, 0 -- returned while the array is unavailable.
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
  // All-zero word decodes as an illegal instruction in the core.
  localparam logic [31:0] ILLEGAL_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IMEM_RUN  = 2'd0,
    IMEM_LOAD = 2'd1,
    IMEM_DONE = 2'd2
  } imem_state_e;

endpackage

// File: rtl/if_ram_1way.sv
// Single-direction RAM read port: master presents a byte address, slave
// returns the addressed word one clock later.
// Latency: 1 cycle. Backpressure: none, the master holds the address to repeat.
interface if_ram_1way;

  logic [jedro_1_defines::DATA_WIDTH-1:0] ram_addr;
  logic [jedro_1_defines::DATA_WIDTH-1:0] ram_rdata;

  modport MASTER (output ram_addr, input ram_rdata);
  modport SLAVE  (input ram_addr, output ram_rdata);

endinterface

// File: rtl/jedro_1_sprom_array.sv
// Word array with one synchronous write port and one synchronous read port.
// Latency: read data valid 1 cycle after i_re; write visible to reads issued
// one cycle after the write edge. Backpressure: none; no reset on the storage.
// Ports: clk_i; i_we/i_waddr/i_wdata write; i_re/i_raddr read; o_rdata.
module jedro_1_sprom_array #(
  parameter int    DEPTH     = 1024,
  parameter int    WIDTH     = 32,
  parameter string INIT_FILE = ""
) (
  input  logic                     clk_i,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk_i) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read register holds its value when not enabled.
  always_ff @(posedge clk_i) begin
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/jedro_1_imem.sv
// Instruction memory slave for the fetch port, plus a valid/ready program loader.
// Latency: instruction returned 1 cycle after the address is sampled.
// Backpressure: fetch has none; loader ready only in LOAD, fetches return NOP
// while loading.
// Ports: clk_i/rstn_i; if_instr_mem (ram_addr in, ram_rdata out);
//        load_start_i/load_data_i/load_valid_i/load_last_i in; load_ready_o,
//        load_busy_o, load_done_o, load_ovf_o, fetch_err_o out.
module jedro_1_imem
  import jedro_1_defines::*;
#(
  parameter int                    MEM_DEPTH_WORDS = 1024,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR       = BOOT_ADDR,
  parameter string                 INIT_FILE       = ""
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  if_ram_1way.SLAVE             if_instr_mem,
  input  logic                  load_start_i,
  input  logic [DATA_WIDTH-1:0] load_data_i,
  input  logic                  load_valid_i,
  input  logic                  load_last_i,
  output logic                  load_ready_o,
  output logic                  load_busy_o,
  output logic                  load_done_o,
  output logic                  load_ovf_o,
  output logic                  fetch_err_o
);

  localparam int AW = $clog2(MEM_DEPTH_WORDS);
  // Array size in bytes, one bit wider than the bus so it cannot overflow.
  localparam logic [DATA_WIDTH:0] MEM_BYTES = (DATA_WIDTH+1)'(longint'(MEM_DEPTH_WORDS) * 4);
  localparam logic [AW:0] LAST_PTR = (AW+1)'(MEM_DEPTH_WORDS - 1);

  imem_state_e           r_state;
  imem_state_e           w_state_nxt;
  // One extra bit so the increment on the final slot never wraps to 0.
  logic [AW:0]           r_wr_ptr;
  logic                  r_ovf;
  logic                  r_rd_good;
  logic                  r_fetch_err;

  logic [DATA_WIDTH-1:0] w_off;
  logic                  w_misaligned;
  logic                  w_oor;
  logic [AW-1:0]         w_idx;
  logic                  w_fetch_en;
  logic                  w_fetch_good;
  logic                  w_fetch_bad;
  logic                  w_accept;
  logic                  w_ptr_at_end;
  logic                  w_ready;
  logic                  w_done;
  logic [31:0]           w_arr_rdata;

  // Address decode; subtraction wraps, so addresses below BASE_ADDR land
  // far out of range.
  assign w_off        = if_instr_mem.ram_addr - BASE_ADDR;
  assign w_misaligned = |w_off[1:0];
  assign w_oor        = {1'b0, w_off} >= MEM_BYTES;
  assign w_idx        = w_off[AW+1:2];

  // Reads only happen in RUN, which also rules out read/write collisions.
  assign w_fetch_en   = (r_state == IMEM_RUN);
  assign w_fetch_good = w_fetch_en && !w_misaligned && !w_oor;
  assign w_fetch_bad  = w_fetch_en && (w_misaligned || w_oor);

  assign w_accept     = load_valid_i && (r_state == IMEM_LOAD);
  assign w_ptr_at_end = (r_wr_ptr == LAST_PTR);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= IMEM_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IMEM_RUN: begin
        if (load_start_i) w_state_nxt = IMEM_LOAD;
      end
      IMEM_LOAD: begin
        w_ready = 1'b1;
        // Last beat, or the array is full: either way the image is closed.
        if (w_accept && (load_last_i || w_ptr_at_end)) w_state_nxt = IMEM_DONE;
      end
      IMEM_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = IMEM_RUN;
      end
      default: w_state_nxt = IMEM_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wr_ptr <= '0;
      r_ovf    <= 1'b0;
    end else if ((r_state == IMEM_RUN) && load_start_i) begin
      r_wr_ptr <= '0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      if (w_ptr_at_end && !load_last_i) r_ovf <= 1'b1;
    end
  end

  // Response select: array data, illegal instruction, or NOP (default).
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_rd_good   <= 1'b0;
      r_fetch_err <= 1'b0;
    end else begin
      r_rd_good   <= w_fetch_good;
      r_fetch_err <= w_fetch_bad;
    end
  end

  jedro_1_sprom_array #(
    .DEPTH     (MEM_DEPTH_WORDS),
    .WIDTH     (32),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk_i   (clk_i),
    .i_we    (w_accept),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (load_data_i),
    .i_re    (w_fetch_good),
    .i_raddr (w_idx),
    .o_rdata (w_arr_rdata)
  );

  assign if_instr_mem.ram_rdata = r_rd_good   ? w_arr_rdata   :
                                  r_fetch_err ? ILLEGAL_INSTR : NOP_INSTR;

  assign load_ready_o = w_ready;
  assign load_busy_o  = (r_state != IMEM_RUN);
  assign load_done_o  = w_done;
  assign load_ovf_o   = r_ovf;
  assign fetch_err_o  = r_fetch_err;

endmodule
